// File: rtl/fsm_seq_driver.sv
// ----------------------------------------------------------------------------
// fsm_seq_driver
//
// Transmit-side companion to the 4-state x_in/y_out sequence detector.
// Takes a target-state request from a control master and drives the
// detector's serial input one bit per clock along the shortest path to that
// state. A shadow copy of the detector state is advanced with every bit
// driven, and the detector's y_out is checked against it.
//
// Ports
//   clock      in   1  rising-edge clock
//   reset      in   1  asynchronous, active-low
//   req_valid  in   1  target request valid
//   req_ready  out  1  high while idle; request accepted on valid && ready
//   req_state  in   2  requested target state (00=S0 .. 11=S3)
//   x_out      out  1  registered serial bit to the detector's x_in
//   busy       out  1  walk in progress
//   done       out  1  one-cycle pulse once the shadow reaches the target
//   shadow     out  2  modelled detector state
//   y_mon      in   1  detector y_out, checked against (shadow != S0)
//   sync_err   out  1  sticky y_mon mismatch flag, cleared only by reset
//
// Controller states
//   state | meaning
//   IDLE  | no walk; x_out parks at HOLD_X, requests accepted
//   RUN   | walking toward target_q; requests ignored
// ----------------------------------------------------------------------------
module fsm_seq_driver #(
    parameter logic HOLD_X = 1'b0
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic [1:0] req_state,
    output logic       x_out,
    output logic       busy,
    output logic       done,
    output logic [1:0] shadow,
    input  logic       y_mon,
    output logic       sync_err
);

    localparam logic [1:0] S0 = 2'b00;
    localparam logic [1:0] S1 = 2'b01;
    localparam logic [1:0] S2 = 2'b10;
    localparam logic [1:0] S3 = 2'b11;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t     state_q, state_d;
    logic [1:0] target_q, target_d;
    logic [1:0] shadow_q, shadow_d;
    logic       x_q, x_d;
    logic       done_q, done_d;
    logic       err_q, err_d;

    logic [1:0] nxt;
    logic       accept;

    // Detector transition function. S2 and S3 have no self-loop.
    function automatic logic [1:0] det_next(input logic [1:0] cur, input logic x);
        logic [1:0] n;
        n = cur;
        case (cur)
            S0:      n = x ? S1 : S0;
            S1:      n = x ? S2 : S1;
            S2:      n = x ? S1 : S3;
            S3:      n = x ? S0 : S2;
            default: n = S0;
        endcase
        return n;
    endfunction

    // First bit of the shortest path from cur to tgt. Ties are broken so
    // that S2 reaches S0 through S3 and S3 reaches S1 through S2.
    function automatic logic path_bit(input logic [1:0] cur, input logic [1:0] tgt);
        logic b;
        b = 1'b0;
        case (cur)
            S0, S1:  b = (tgt != cur);
            S2:      b = (tgt == S1);
            S3:      b = (tgt == S0);
            default: b = 1'b0;
        endcase
        return b;
    endfunction

    assign req_ready = (state_q == IDLE);
    assign accept    = req_valid && req_ready;

    // The detector samples x_out on every edge, idle or not, so the shadow
    // always advances with the bit currently on the wire.
    assign nxt = det_next(shadow_q, x_q);

    always_comb begin
        state_d  = state_q;
        target_d = target_q;
        x_d      = HOLD_X;
        done_d   = 1'b0;
        shadow_d = nxt;
        err_d    = err_q | (y_mon != (shadow_q != S0));

        case (state_q)
            IDLE: begin
                if (accept) begin
                    target_d = req_state;
                    // The walk plans from where the detector will be after
                    // this edge, not from the current shadow.
                    if (nxt == req_state) begin
                        done_d = 1'b1;
                    end else begin
                        state_d = RUN;
                        x_d     = path_bit(nxt, req_state);
                    end
                end
            end
            RUN: begin
                if (nxt == target_q) begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                end else begin
                    x_d = path_bit(nxt, target_q);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            target_q <= S0;
            shadow_q <= S0;
            x_q      <= HOLD_X;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            target_q <= target_d;
            shadow_q <= shadow_d;
            x_q      <= x_d;
            done_q   <= done_d;
            err_q    <= err_d;
        end
    end

    assign busy     = (state_q == RUN);
    assign done     = done_q;
    assign x_out    = x_q;
    assign shadow   = shadow_q;
    assign sync_err = err_q;

endmodule

// File: tb/tb_fsm_seq_driver.sv
module tb_fsm_seq_driver;

    logic       clock;
    logic       reset;
    logic       req_valid;
    logic       req_ready;
    logic [1:0] req_state;
    logic       x_out;
    logic       busy;
    logic       done;
    logic [1:0] shadow;
    logic       y_mon;
    logic       sync_err;

    int n_vec;
    int n_err;
    logic [1:0] sh_prev;

    fsm_seq_driver #(.HOLD_X(1'b0)) dut (
        .clock     (clock),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_state (req_state),
        .x_out     (x_out),
        .busy      (busy),
        .done      (done),
        .shadow    (shadow),
        .y_mon     (y_mon),
        .sync_err  (sync_err)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        string      name;
        logic       v;
        logic [1:0] rs;
        logic       yf;
        logic       ex;
        logic [1:0] esh;
        logic       ebusy;
        logic       edone;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input string nm, input logic v, input logic [1:0] rs, input logic yf,
                       input logic ex, input logic [1:0] esh, input logic eb, input logic ed);
        vec_t t;
        t.name = nm; t.v = v; t.rs = rs; t.yf = yf;
        t.ex = ex; t.esh = esh; t.ebusy = eb; t.edone = ed;
        vecs.push_back(t);
    endtask

    task automatic check(input string nm, input logic ex, input logic [1:0] esh,
                         input logic eb, input logic ed, input logic erdy, input logic eerr);
        n_vec++;
        if ({x_out, shadow, busy, done, req_ready, sync_err} !== {ex, esh, eb, ed, erdy, eerr}) begin
            n_err++;
            $display("FAIL %s: got x=%b sh=%0d busy=%b done=%b rdy=%b err=%b, want x=%b sh=%0d busy=%b done=%b rdy=%b err=%b",
                     nm, x_out, shadow, busy, done, req_ready, sync_err,
                     ex, esh, eb, ed, erdy, eerr);
        end
    endtask

    // Drive at the falling edge, let one rising edge pass, check 1 time unit later.
    // y_mon follows the expected detector state unless yf forces a mismatch.
    task automatic step(input string nm, input logic v, input logic [1:0] rs, input logic yf,
                        input logic ex, input logic [1:0] esh, input logic eb, input logic ed,
                        input logic eerr);
        req_valid = v;
        req_state = rs;
        y_mon     = (sh_prev != 2'd0) ^ yf;
        @(posedge clock);
        #1;
        check(nm, ex, esh, eb, ed, !eb, eerr);
        sh_prev = esh;
        @(negedge clock);
    endtask

    initial begin
        n_vec     = 0;
        n_err     = 0;
        sh_prev   = 2'd0;
        reset     = 1'b0;
        req_valid = 1'b0;
        req_state = 2'd0;
        y_mon     = 1'b0;

        //         name        v  rs yf  x  sh busy done
        for (int i = 0; i < 5; i++)
            add("idle",        0, 0, 0,  0, 0, 0, 0);
        add("s3_accept",       1, 3, 0,  1, 0, 1, 0);
        add("s3_bit1",         0, 0, 0,  1, 1, 1, 0);
        add("s3_bit2",         0, 0, 0,  0, 2, 1, 0);
        add("s3_done",         0, 0, 0,  0, 3, 0, 1);
        add("s0_on_done",      1, 0, 0,  0, 2, 1, 0);
        add("s0_bit1",         0, 0, 0,  1, 3, 1, 0);
        add("s0_done",         0, 0, 0,  0, 0, 0, 1);
        add("s0_gap",          0, 0, 0,  0, 0, 0, 0);
        add("s0_to_s0",        1, 0, 0,  0, 0, 0, 1);
        add("s0_to_s0_after",  0, 0, 0,  0, 0, 0, 0);
        add("ign_accept",      1, 3, 0,  1, 0, 1, 0);
        add("ign_req1",        1, 1, 0,  1, 1, 1, 0);
        add("ign_req2",        1, 1, 0,  0, 2, 1, 0);
        add("ign_done",        0, 0, 0,  0, 3, 0, 1);
        add("drift1",          0, 0, 0,  0, 2, 0, 0);
        add("drift2",          0, 0, 0,  0, 3, 0, 0);
        add("drift3",          0, 0, 0,  0, 2, 0, 0);
        add("s1_accept",       1, 1, 0,  0, 3, 1, 0);
        add("s1_bit1",         0, 0, 0,  1, 2, 1, 0);
        add("s1_done",         0, 0, 0,  0, 1, 0, 1);
        add("s1_park",         0, 0, 0,  0, 1, 0, 0);
        add("s2_accept",       1, 2, 0,  1, 1, 1, 0);
        add("s2_done",         0, 0, 0,  0, 2, 0, 1);
        add("s2_drift",        0, 0, 0,  0, 3, 0, 0);
        add("back_accept",     1, 0, 0,  0, 2, 1, 0);
        add("back_bit1",       0, 0, 0,  1, 3, 1, 0);
        add("back_done",       0, 0, 0,  0, 0, 0, 1);

        repeat (3) @(posedge clock);
        @(negedge clock);
        check("reset_vals", 0, 0, 0, 0, 1, 0);
        reset = 1'b1;

        foreach (vecs[i])
            step(vecs[i].name, vecs[i].v, vecs[i].rs, vecs[i].yf,
                 vecs[i].ex, vecs[i].esh, vecs[i].ebusy, vecs[i].edone, 1'b0);

        // y_mon disagrees with shadow=S0 for one cycle; the flag must stick.
        step("y_force",  0, 0, 1,  0, 0, 0, 0, 1);
        step("y_stick1", 0, 0, 0,  0, 0, 0, 0, 1);
        step("y_stick2", 0, 0, 0,  0, 0, 0, 0, 1);

        // Reset asserted mid-walk toward S3, after the first bit was applied.
        step("rw_accept", 1, 3, 0,  1, 0, 1, 0, 1);
        step("rw_bit1",   0, 0, 0,  1, 1, 1, 0, 1);
        req_valid = 1'b0;
        y_mon     = 1'b0;
        reset     = 1'b0;
        #1;
        check("rw_async", 0, 0, 0, 0, 1, 0);
        @(posedge clock);
        #1;
        check("rw_held", 0, 0, 0, 0, 1, 0);
        @(negedge clock);
        reset   = 1'b1;
        sh_prev = 2'd0;
        for (int i = 0; i < 4; i++)
            step("rw_after", 0, 0, 0,  0, 0, 0, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
